// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate one-word-line data cache
// sitting between the MEM-stage load/store port and data memory.
module data_cache #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SETS       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  hit,
    output logic                  valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int unsigned IDX   = $clog2(SETS);
    localparam int unsigned TAG_W = 32 - IDX - 2;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t                state_q, state_d;
    logic                  done_q, done_d;
    logic [31:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  valid_q [SETS];
    logic                  valid_d [SETS];
    logic [TAG_W-1:0]      tag_q   [SETS];
    logic [TAG_W-1:0]      tag_d   [SETS];
    logic [DATA_WIDTH-1:0] data_q  [SETS];
    logic [DATA_WIDTH-1:0] data_d  [SETS];

    logic [IDX-1:0]        idx, txn_idx;
    logic [TAG_W-1:0]      tag, txn_tag;
    logic                  txn_hit;

    assign idx     = addr[IDX+1:2];
    assign tag     = addr[31:IDX+2];
    assign txn_idx = addr_q[IDX+1:2];
    assign txn_tag = addr_q[31:IDX+2];
    assign txn_hit = valid_q[txn_idx] && (tag_q[txn_idx] == txn_tag);

    function automatic logic [DATA_WIDTH-1:0] load_extract(
        input logic [DATA_WIDTH-1:0] w,
        input logic [1:0]            off,
        input logic [2:0]            f3
    );
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b001:  r = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, h};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Unsupported store widths leave the cached word untouched.
    function automatic logic [DATA_WIDTH-1:0] store_merge(
        input logic [DATA_WIDTH-1:0] w,
        input logic [DATA_WIDTH-1:0] d,
        input logic [1:0]            off,
        input logic [2:0]            f3
    );
        logic [DATA_WIDTH-1:0] r;
        r = w;
        case (f3)
            3'b000: r[{off, 3'b000} +: 8] = d[7:0];
            3'b001: begin
                if (off[1]) r[31:16] = d[15:0];
                else        r[15:0]  = d[15:0];
            end
            3'b010:  r = d;
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        data_d     = data_q;
        rdata      = '0;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = '0;
        valid      = req & valid_q[idx];
        hit        = valid & (tag_q[idx] == tag);

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (we) begin
                        // done_q marks the retire cycle of a store just written through
                        if (!done_q) begin
                            stall    = 1'b1;
                            state_d  = WRITE;
                            addr_d   = addr;
                            wdata_d  = wdata;
                            funct3_d = funct3;
                        end
                    end else if (hit) begin
                        rdata = load_extract(data_q[idx], addr[1:0], funct3);
                    end else begin
                        stall    = 1'b1;
                        state_d  = FETCH;
                        addr_d   = addr;
                        wdata_d  = wdata;
                        funct3_d = funct3;
                    end
                end
            end
            FETCH: begin
                stall      = 1'b1;
                mem_req    = 1'b1;
                mem_addr   = {addr_q[31:2], 2'b00};
                mem_funct3 = 3'b010;
                if (mem_ack) begin
                    valid_d[txn_idx] = 1'b1;
                    tag_d[txn_idx]   = txn_tag;
                    data_d[txn_idx]  = mem_rdata;
                    state_d          = IDLE;
                end
            end
            WRITE: begin
                stall      = 1'b1;
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                mem_funct3 = funct3_q;
                if (mem_ack) begin
                    if (txn_hit) begin
                        data_d[txn_idx] = store_merge(data_q[txn_idx], wdata_q, addr_q[1:0], funct3_q);
                    end
                    done_d  = req;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) stall = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            for (int i = 0; i < int'(SETS); i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache: a behavioural line/memory model plus a
// bench-side memory responder with random ack latency.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        stall, hit, valid;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    data_cache #(.DATA_WIDTH(32), .SETS(8)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .funct3(funct3), .rdata(rdata), .stall(stall), .hit(hit), .valid(valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: per-set valid/line-number/data, and a sparse word memory.
    bit          m_valid [8];
    int unsigned m_tag   [8];
    logic [31:0] m_data  [8];
    logic [31:0] mem_model [int unsigned];

    logic [31:0] last_rdata;
    logic        last_hit;
    int          last_stalls;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_mem(input int unsigned wa);
        if (!mem_model.exists(wa)) mem_model[wa] = $urandom;
        return mem_model[wa];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int unsigned a, input logic [2:0] f3);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * (a % 4))) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            3'd2:    v = w;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input int unsigned a,
                                              input logic [31:0] d, input logic [2:0] f3);
        int unsigned sh;
        logic [31:0] mask;
        case (f3)
            3'd0: begin
                sh = 8 * (a % 4);
                mask = 32'hFF << sh;
                return (w & ~mask) | ((d & 32'hFF) << sh);
            end
            3'd1: begin
                sh = 16 * ((a / 2) % 2);
                mask = 32'hFFFF << sh;
                return (w & ~mask) | ((d & 32'hFFFF) << sh);
            end
            3'd2:    return d;
            default: return w;
        endcase
    endfunction

    // One pipeline access; the bench plays memory, acking after dly_in cycles (random if < 0).
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f3, input int dly_in);
        int unsigned i, t, wa, dly;
        bit          ev, eh;
        logic [31:0] fill;
        i  = (a >> 2) % 8;
        t  = a >> 5;
        wa = a >> 2;
        ev = m_valid[i];
        eh = ev && (m_tag[i] == t);
        last_stalls = 0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; funct3 = f3;
        #1;
        check("valid", valid, 32'(ev));
        check("hit", hit, 32'(eh));
        last_hit = hit;
        if (!w && eh) begin
            check("stall_hit", stall, 0);
            check("rdata_hit", rdata, ref_load(m_data[i], a, f3));
            last_rdata = rdata;
        end else begin
            check("stall_c0", stall, 1);
            check("mem_req_c0", mem_req, 0);
            check("rdata_c0", rdata, 0);
            if (stall) last_stalls++;
            dly  = (dly_in < 0) ? $urandom_range(0, 3) : dly_in;
            fill = get_mem(wa);
            for (int k = 0; k <= int'(dly); k++) begin
                @(negedge clk);
                if (k == int'(dly)) begin
                    mem_ack = 1'b1; mem_rdata = fill;
                end else begin
                    mem_rdata = $urandom;
                end
                #1;
                check("stall_txn", stall, 1);
                if (stall) last_stalls++;
                check("mem_req", mem_req, 1);
                check("mem_we", mem_we, 32'(w));
                check("mem_addr", mem_addr, w ? a : (a & 32'hFFFF_FFFC));
                check("mem_wdata", mem_wdata, w ? d : 32'h0);
                check("mem_funct3", mem_funct3, w ? 32'(f3) : 32'd2);
            end
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = $urandom;
            if (w) begin
                if (eh) m_data[i] = ref_store(m_data[i], a, d, f3);
                mem_model[wa] = ref_store(fill, a, d, f3);
            end else begin
                m_valid[i] = 1'b1; m_tag[i] = t; m_data[i] = fill;
            end
            #1;
            check("stall_done", stall, 0);
            check("mem_req_done", mem_req, 0);
            if (!w) begin
                check("hit_after_fill", hit, 1);
                check("rdata_fill", rdata, ref_load(fill, a, f3));
                last_rdata = rdata;
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req = 1'b0; we = 1'($urandom); addr = $urandom_range(0, 255);
        #1;
        check("idle_hit", hit, 0);
        check("idle_valid", valid, 0);
        check("idle_stall", stall, 0);
        check("idle_rdata", rdata, 0);
        check("idle_mem_req", mem_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] ld_f3 [6];
        logic [2:0] st_f3 [4];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
        st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3};
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0; m_tag[s] = 0; m_data[s] = '0;
        end

        rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h1234;
        funct3 = 3'd2; mem_ack = 1'b0; mem_rdata = '0;
        #2;
        check("rst_stall", stall, 0);
        check("rst_hit", hit, 0);
        check("rst_valid", valid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_funct3", mem_funct3, 0);
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        idle_cycle();

        mem_model[32'h40 >> 2] = 32'hDEAD_BEEF;
        access(1'b0, 32'h40, 0, 3'd2, 0);
        check("pl_first_miss", last_hit, 0);
        check("pl_miss_stalls", last_stalls, 2);
        check("pl_lw40", last_rdata, 32'hDEAD_BEEF);
        access(1'b0, 32'h40, 0, 3'd2, -1);
        check("pl_lw40_hit", last_hit, 1);

        access(1'b1, 32'h40, 32'h80FF_7F01, 3'd2, 0);
        check("pl_sw_stalls", last_stalls, 2);
        access(1'b0, 32'h43, 0, 3'd0, -1);
        check("pl_lb43", last_rdata, 32'hFFFF_FF80);
        access(1'b0, 32'h41, 0, 3'd4, -1);
        check("pl_lbu41", last_rdata, 32'h0000_007F);
        access(1'b0, 32'h42, 0, 3'd1, -1);
        check("pl_lh42", last_rdata, 32'hFFFF_80FF);
        access(1'b0, 32'h40, 0, 3'd5, -1);
        check("pl_lhu40", last_rdata, 32'h0000_7F01);

        access(1'b1, 32'h41, 32'hAB, 3'd0, -1);
        access(1'b0, 32'h40, 0, 3'd2, -1);
        check("pl_sb_merge", last_rdata, 32'h80FF_AB01);

        access(1'b1, 32'h80, 32'h1234_5678, 3'd2, -1);
        access(1'b0, 32'h80, 0, 3'd2, -1);
        check("pl_no_allocate", last_hit, 0);
        check("pl_lw80", last_rdata, 32'h1234_5678);

        access(1'b0, 32'h00, 0, 3'd2, -1);
        access(1'b0, 32'h20, 0, 3'd2, -1);
        access(1'b0, 32'h00, 0, 3'd2, -1);
        check("pl_evicted", last_hit, 0);

        // Abandon a fetch with reset; the stray ack that follows must be ignored.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h1004; funct3 = 3'd2;
        #1 check("rm_stall", stall, 1);
        @(negedge clk);
        #1 check("rm_mem_req", mem_req, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rm_mem_req_drop", mem_req, 0);
        check("rm_stall_drop", stall, 0);
        check("rm_valid", valid, 0);
        @(negedge clk);
        rst = 1'b0; req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1 check("rm_late_ack", mem_req, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        for (int s = 0; s < 8; s++) m_valid[s] = 1'b0;
        #1 check("rm_idle_stall", stall, 0);
        access(1'b0, 32'h1004, 0, 3'd2, -1);
        check("rm_refetch", last_hit, 0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] ra;
            ra = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) idle_cycle();
            if ($urandom_range(0, 2) == 0)
                access(1'b1, ra, $urandom, st_f3[$urandom_range(0, 3)], -1);
            else
                access(1'b0, ra, $urandom, ld_f3[$urandom_range(0, 5)], -1);
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the MEM-stage load/store request and `dataMemory`. Load hits return sign- or zero-extended data with no wait. Load misses and all stores stall the pipeline while a single-word transaction runs to memory over a req/ack handshake. `hit` and `valid` are exported as the cache-hit and validity signals for the memory side.

## Interface
- `DATA_WIDTH`, 32, word width; only 32 is supported.
- `SETS`, 8, number of one-word lines; must be a power of 2, at least 2.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `req` input 1: MEM-stage access request. Held stable while `stall` is high.
- `we` input 1: 1 = store, 0 = load.
- `addr` input 32: byte address from the ALU.
- `wdata` input 32: store data, right-justified.
- `funct3` input 3: access type (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010).
- `rdata` output 32: load result, already extended.
- `stall` output 1: freezes the pipeline.
- `hit` output 1: the current lookup hits.
- `valid` output 1: valid bit of the indexed line.
- `mem_req` output 1: memory transaction request.
- `mem_we` output 1: 1 = write-through, 0 = line fetch.
- `mem_addr` output 32: byte address for the transaction.
- `mem_wdata` output 32: store data.
- `mem_funct3` output 3: transaction access type.
- `mem_rdata` input 32: full word returned by a fetch.
- `mem_ack` input 1: one-cycle completion pulse.

## Operation
- **Address split.**
  - IDX = log2(SETS).
  - Index = `addr[IDX+1:2]`.
  - Tag = `addr[31:IDX+2]`.
  - Offset = `addr[1:0]`.
- **Line storage.** Each line holds a valid bit, a tag and one data word.
- **Hit definition.** `valid` = valid bit of the indexed line; `hit` = `valid` & (tag match). Both are combinational and are driven whenever `req` is high; otherwise both are 0.
- **States:** IDLE, FETCH, WRITE.
- **IDLE**
  - Load hit: `rdata` is extracted combinationally; `stall` = 0; state stays IDLE.
    - lb/lbu take the byte at the offset.
    - lh/lhu take the halfword at `addr[1]`.
    - lw takes the whole word, ignoring the offset.
    - lb/lh sign-extend; lbu/lhu zero-extend.
    - Any other funct3 returns 0.
  - Load miss: `stall` = 1; next state FETCH.
  - Store (`req` & `we`), hit or miss: `stall` = 1; next state WRITE.
  - No `req`: `stall` = 0; `rdata` = 0.
- **FETCH**
  - `mem_req` = 1, `mem_we` = 0, `mem_funct3` = 010, `mem_addr` = `{addr[31:2],2'b00}`; `stall` = 1.
  - On the `mem_ack` edge: write the line (valid = 1, tag, data = `mem_rdata`), then go to IDLE. The access then completes there as a hit.
- **WRITE**
  - `mem_req` = 1, `mem_we` = 1, `mem_addr` = `addr`, `mem_wdata` = `wdata`, `mem_funct3` = `funct3`; `stall` = 1.
  - On the `mem_ack` edge: if the line hits, merge the store into the cached word (sb byte at offset, sh halfword at `addr[1]`, sw whole word). On a miss the line is untouched (no allocate). Then go to IDLE, where `stall` = 0 and the store retires.
  - Because the state is then IDLE, a held store `req` must not re-enter WRITE on that cycle. A one-bit `done` flag, set on ack and cleared when `req` falls or a new access begins, implements this.
- **Memory-side outputs outside FETCH/WRITE.** `mem_req` = 0, `mem_we` = 0; the other `mem_*` outputs are 0.
- **Unsupported store funct3.** Still written through to memory; the cached line is left unchanged.
- **`req` dropped during FETCH/WRITE.** The transaction still completes, including the line fill or merge.

## Timing
- **Reset.** While `rst` is asserted, asynchronously:
  - all valid bits are cleared and the state goes to IDLE;
  - `mem_req`, `mem_we`, `stall`, `hit`, `valid`, `rdata` and the `mem_*` buses are all 0.
- **Reset mid-transaction.** An in-flight FETCH/WRITE is abandoned and `mem_req` drops immediately. A late `mem_ack` arriving in IDLE is ignored.
- **Load hit latency:** 0 cycles; data is valid in the cycle `req` is high.
- **Load miss.**
  - Cycle 0: detect, `stall` = 1.
  - Cycle 1 onward: `mem_req` = 1.
  - Ack sampled at the end of cycle k: the cycle after is IDLE, with the hit data and `stall` = 0.
  - Minimum penalty is 2 stall cycles.
- **Store:** minimum 2 stall cycles, with the same handshake as a load miss.
- **Handshake rules.**
  - `mem_req` and all `mem_*` outputs are stable from assertion until the ack edge.
  - `mem_ack` is only sampled in FETCH/WRITE.
  - `mem_req` deasserts the cycle after the ack.
- **Aliasing.** Addresses differing only in the tag evict each other on fill; there is no replacement choice.

## Test plan
- **Reset then load hit.** Assert `rst`: all outputs 0. Load lw 0x40: miss, FETCH. Ack with 0xDEADBEEF: lw 0x40 then hits, `rdata` = 0xDEADBEEF, 2 stall cycles.
- **Load extension on a cached line.** Cached word 0x80FF7F01 at 0x40:
  - lb 0x43 → 0xFFFFFF80;
  - lbu 0x41 → 0x0000007F;
  - lh 0x42 → 0xFFFF80FF;
  - lhu 0x40 → 0x00007F01.
  All four with `stall` = 0.
- **Store hit.** sb 0x41 with `wdata` 0xAB issues `mem_we` = 1, `mem_addr` = 0x41, `mem_funct3` = 000. After the ack, lw 0x40 hits and returns 0x80FFAB01.
- **Store miss.** sw 0x80 (index 0, different tag than 0x40) writes through. After the ack, lw 0x80 misses with `hit` = 0 (no allocate).
- **Conflict eviction.** With SETS = 8, fill 0x00, then fill 0x20. A load of 0x00 misses again and refetches.
- **Reset mid-transaction.** Assert `rst` mid-FETCH: `mem_req` falls immediately. A following ack is ignored, and the next load of the same address misses.
